dsp48e2_simd_alu: RTL and testbench
===================================

Name: dsp48e2_simd_alu

Overview:
- Behavioural model of the DSP48E2 post-adder/ALU path, with the multiplier and pre-adder removed.
- Adds or subtracts the 48-bit concatenation A:B, C, the fed-back P and constants, split into SIMD lanes (one 48-bit, two 24-bit or four 12-bit).
- Used by the dual-lane adder wrappers, e.g. two independent 24-bit adds in one block.
- Optional output register P.

Parameters:
- USE_SIMD, "TWO24", lane split: "ONE48", "TWO24" or "FOUR12"; any other value behaves as "ONE48".
- PREG, 0, output register stages on P/CARRYOUT: 0 (combinational) or 1 (registered).

Ports:
- clock  input  1  single clock; used only when PREG=1.
- reset  input  1  synchronous, active-high; clears P and CARRYOUT registers.
- cep  input  1  clock enable for the P/CARRYOUT registers.
- a  input  30  upper part of X operand, AB[47:18].
- b  input  18  lower part of X operand, AB[17:0].
- c  input  48  C operand.
- carryin  input  1  carry into lane 0 only.
- alumode  input  4  ALU function select.
- opmode  input  9  W/Z/Y/X multiplexer selects.
- p  output  48  result.
- carryout  output  4  per-lane carry outputs.

Behaviour:
- AB = {a,b}, 48 bits.
- X mux, opmode[1:0]:
  - 00 → 0
  - 10 → P_reg
  - 11 → AB
  - 01 → 0 (multiplier not modelled)
- Y mux, opmode[3:2]:
  - 11 → 48'hFFFF_FFFF_FFFF
  - else → 0
- Z mux, opmode[6:4]:
  - 000 → 0
  - 010 → P_reg
  - 011 → C
  - else → 0
- W mux, opmode[8:7]:
  - 11 → C
  - else → 0
- P_reg is the registered P. When PREG=0, a P select yields 0; no combinational loop.
- Lanes, bits [k*L +: L] with L = 48 / 24 / 12 for ONE48 / TWO24 / FOUR12:
  - Each lane computes independently; no carry crosses a lane boundary.
  - carryin is added to lane 0 only.
- Per-lane sum S = W + X + Y + CIN. ALU function by alumode:
  - 0000: Z + S
  - 0001: ~Z + S
  - 0010: ~(Z + S)
  - 0011: ~(~Z + S), i.e. Z − S
  - any other code behaves as 0000.
- Each lane result is truncated to L bits (modular wrap-around).
- carryout is the raw carry-out of each lane's internal adder, taken before the final inversion:
  - ONE48: bit 3 only.
  - TWO24: bit 1 = lane 0, bit 3 = lane 1.
  - FOUR12: bits 0–3 = lanes 0–3.
  - Unused bits read 0.
- PREG=0:
  - p and carryout are purely combinational, zero latency.
  - reset and cep are ignored.
- PREG=1:
  - On the rising clock edge: reset=1 → P and CARRYOUT registers become 0 (reset has priority over cep).
  - Else cep=1 → registers load the ALU result.
  - Else registers hold.
  - Latency is 1 cycle.
  - P feedback uses the current register value, which enables accumulate: opmode Z=010, X=11.
- Initial/power-up register value: 0.
- Reset asserted mid-accumulation: the next cycle reads p=0, and accumulation restarts from 0 after reset deasserts.

Decomposition:
- Shared package dsp_pkg holds:
  - SIMD mode enum (ONE48, TWO24, FOUR12)
  - ALUMODE constants (ADD=0000, SUB=0011, NOTZ_ADD=0001, NOT_SUM=0010)
  - OPMODE field constants (X_AB, X_P, Y_ONES, Z_C, Z_P, W_C)
- One natural sub-module: dsp_simd_lane. It is a parameterised L-bit adder/inverter lane that computes the result and carry-out. It is instantiated 4x12-bit, with carry linking controlled by the SIMD mode.
- Top level holds the muxes, lane split and the P register.

Test Plan:
- TWO24, PREG=0, alumode=0000, opmode=9'b000110011, c=48'h000005_000003, AB=48'h000007_000004 → p=48'h00000C_000007, carryout=0000.
- TWO24 lane wrap: c=48'h000001_FFFFFF, AB=48'h000002_000001 → p=48'h000003_000000, carryout=0010 (lane 1 unaffected). ONE48 with the same inputs → p=48'h000004_000000, carryout=0000.
- FOUR12: c=48'h001_002_FFF_004, AB=48'h001_001_001_001 → p=48'h002_003_000_005, carryout=0010.
- Subtract, TWO24, alumode=0011: c=48'h000010_000003, AB=48'h000001_000005 → p=48'h00000F_FFFFFE.
- PREG=1, ONE48, opmode=9'b000100011 (Z=P, X=AB), AB=1, cep=1 for 3 cycles → p=1, 2, 3. cep=0 → p holds 3. reset=1 → p=0 on the next edge.
- PREG=1: reset and cep both 1 → p=0. carryin=1 with ADD, AB=0, c=0 → p=48'h000000_000001 (lane 0 only).

Source files
------------

// File: rtl/dsp_pkg.sv
// Shared types and constants for the SIMD post-adder/ALU: lane split modes,
// ALUMODE codes, OPMODE field values and the segment carry-link map.
package dsp_pkg;

  typedef enum logic [1:0] {
    ONE48  = 2'd0,
    TWO24  = 2'd1,
    FOUR12 = 2'd2
  } simd_mode_e;

  localparam int SEG_W  = 12;
  localparam int N_SEG  = 4;
  localparam int DATA_W = SEG_W * N_SEG;

  localparam logic [3:0] ALU_ADD      = 4'b0000;
  localparam logic [3:0] ALU_NOTZ_ADD = 4'b0001;
  localparam logic [3:0] ALU_NOT_SUM  = 4'b0010;
  localparam logic [3:0] ALU_SUB      = 4'b0011;

  localparam logic [1:0] X_P    = 2'b10;
  localparam logic [1:0] X_AB   = 2'b11;
  localparam logic [1:0] Y_ONES = 2'b11;
  localparam logic [2:0] Z_P    = 3'b010;
  localparam logic [2:0] Z_C    = 3'b011;
  localparam logic [1:0] W_C    = 2'b11;

  // Bit s set means 12-bit segment s takes its carry from segment s-1,
  // i.e. segments s-1 and s belong to the same SIMD lane.
  function automatic logic [3:0] seg_link(input simd_mode_e mode);
    logic [3:0] link;
    case (mode)
      TWO24:   link = 4'b1010;
      FOUR12:  link = 4'b0000;
      default: link = 4'b1110;
    endcase
    return link;
  endfunction

endpackage

// File: rtl/dsp48e2_simd_alu_if.sv
// Operand/result bundle of the SIMD ALU; the master drives operands and
// controls, the slave returns P and the per-lane carries.
interface dsp48e2_simd_alu_if;
  logic        cep;
  logic [29:0] a;
  logic [17:0] b;
  logic [47:0] c;
  logic        carryin;
  logic [3:0]  alumode;
  logic [8:0]  opmode;
  logic [47:0] p;
  logic [3:0]  carryout;

  modport master (
    output cep, a, b, c, carryin, alumode, opmode,
    input  p, carryout
  );

  modport slave (
    input  cep, a, b, c, carryin, alumode, opmode,
    output p, carryout
  );
endinterface

// File: rtl/dsp_simd_lane.sv
// One W-bit segment of the post-adder: optional Z inversion, four-operand
// add with a 2-bit chained carry, optional output inversion.
module dsp_simd_lane
  import dsp_pkg::*;
#(
  parameter int W = 12
) (
  input  logic [W-1:0] w,
  input  logic [W-1:0] x,
  input  logic [W-1:0] y,
  input  logic [W-1:0] z,
  input  logic [1:0]   cin,
  input  logic [3:0]   alumode,
  output logic [W-1:0] res,
  output logic [1:0]   cout
);

  logic         inv_z;
  logic         inv_out;
  logic [W-1:0] z_eff;
  logic [W+1:0] sum_full;

  // Four W-bit operands plus a carry of up to 3 fit in W+2 bits, so the
  // upper two bits carry exactly into the next segment when chained.
  always_comb begin
    inv_z    = (alumode == ALU_NOTZ_ADD) || (alumode == ALU_SUB);
    inv_out  = (alumode == ALU_NOT_SUM)  || (alumode == ALU_SUB);
    z_eff    = inv_z ? ~z : z;
    sum_full = {2'b00, w} + {2'b00, x} + {2'b00, y} + {2'b00, z_eff}
             + {{W{1'b0}}, cin};
    res      = inv_out ? ~sum_full[W-1:0] : sum_full[W-1:0];
    cout     = sum_full[W+1:W];
  end

endmodule

// File: rtl/dsp48e2_simd_alu.sv
// DSP48E2-style post-adder/ALU without multiplier: W/X/Y/Z muxes, SIMD lane
// split over four 12-bit segments, optional P/CARRYOUT register.
module dsp48e2_simd_alu
  import dsp_pkg::*;
#(
  parameter string USE_SIMD = "TWO24",
  parameter int    PREG     = 0
) (
  input  logic                 clock,
  input  logic                 reset,
  dsp48e2_simd_alu_if.slave    bus
);

  localparam simd_mode_e MODE = (USE_SIMD == "FOUR12") ? FOUR12 :
                                (USE_SIMD == "TWO24")  ? TWO24  : ONE48;
  localparam logic [3:0] LINK   = seg_link(MODE);
  localparam bit         PREG_ON = (PREG != 0);

  logic [DATA_W-1:0] ab;
  logic [DATA_W-1:0] p_fb;
  logic [DATA_W-1:0] w_mux;
  logic [DATA_W-1:0] x_mux;
  logic [DATA_W-1:0] y_mux;
  logic [DATA_W-1:0] z_mux;
  logic [DATA_W-1:0] p_alu;
  logic [3:0]        co_alu;
  logic [1:0]        seg_cout [N_SEG];

  logic [DATA_W-1:0] p_d;
  logic [DATA_W-1:0] p_q;
  logic [3:0]        co_d;
  logic [3:0]        co_q;

  assign ab = {bus.a, bus.b};
  // Without the output register there is no P to feed back; returning 0
  // keeps the datapath free of a combinational loop.
  assign p_fb = PREG_ON ? p_q : '0;

  always_comb begin
    x_mux = '0;
    y_mux = '0;
    z_mux = '0;
    w_mux = '0;
    case (bus.opmode[1:0])
      X_AB:    x_mux = ab;
      X_P:     x_mux = p_fb;
      default: x_mux = '0;
    endcase
    if (bus.opmode[3:2] == Y_ONES) begin
      y_mux = '1;
    end
    case (bus.opmode[6:4])
      Z_C:     z_mux = bus.c;
      Z_P:     z_mux = p_fb;
      default: z_mux = '0;
    endcase
    if (bus.opmode[8:7] == W_C) begin
      w_mux = bus.c;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < N_SEG; gi++) begin : g_seg
      logic [1:0] cin_seg;

      if (gi == 0) begin : g_first
        assign cin_seg = {1'b0, bus.carryin};
      end else begin : g_chain
        assign cin_seg = LINK[gi] ? seg_cout[gi-1] : 2'b00;
      end

      dsp_simd_lane #(.W(SEG_W)) u_lane (
        .w       (w_mux[gi*SEG_W +: SEG_W]),
        .x       (x_mux[gi*SEG_W +: SEG_W]),
        .y       (y_mux[gi*SEG_W +: SEG_W]),
        .z       (z_mux[gi*SEG_W +: SEG_W]),
        .cin     (cin_seg),
        .alumode (bus.alumode),
        .res     (p_alu[gi*SEG_W +: SEG_W]),
        .cout    (seg_cout[gi])
      );

      // A lane reports its carry on the bit of its most significant segment.
      if (gi == N_SEG - 1) begin : g_top
        assign co_alu[gi] = |seg_cout[gi];
      end else begin : g_mid
        assign co_alu[gi] = LINK[gi+1] ? 1'b0 : |seg_cout[gi];
      end
    end
  endgenerate

  always_comb begin
    p_d  = p_q;
    co_d = co_q;
    if (bus.cep) begin
      p_d  = p_alu;
      co_d = co_alu;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      p_q  <= '0;
      co_q <= '0;
    end else begin
      p_q  <= p_d;
      co_q <= co_d;
    end
  end

  assign bus.p        = PREG_ON ? p_q  : p_alu;
  assign bus.carryout = PREG_ON ? co_q : co_alu;

endmodule

// File: tb/tb_dsp48e2_simd_alu.sv
// Directed scoreboard bench: three combinational instances (TWO24/ONE48/
// FOUR12) sharing one operand set, plus a registered ONE48 accumulator.
module tb_dsp48e2_simd_alu;

  typedef struct {
    string       tag;
    logic [47:0] p;
    logic [3:0]  co;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  logic        clock = 1'b0;
  logic        reset = 1'b1;

  logic [47:0] s_ab;
  logic [47:0] s_c;
  logic        s_cin;
  logic [3:0]  s_alu;
  logic [8:0]  s_op;

  dsp48e2_simd_alu_if if_two24 ();
  dsp48e2_simd_alu_if if_one48 ();
  dsp48e2_simd_alu_if if_four12 ();
  dsp48e2_simd_alu_if if_acc ();

  always #5 clock = ~clock;

  assign {if_two24.a, if_two24.b}   = s_ab;
  assign {if_one48.a, if_one48.b}   = s_ab;
  assign {if_four12.a, if_four12.b} = s_ab;
  assign if_two24.c  = s_c;
  assign if_one48.c  = s_c;
  assign if_four12.c = s_c;
  assign if_two24.carryin  = s_cin;
  assign if_one48.carryin  = s_cin;
  assign if_four12.carryin = s_cin;
  assign if_two24.alumode  = s_alu;
  assign if_one48.alumode  = s_alu;
  assign if_four12.alumode = s_alu;
  assign if_two24.opmode   = s_op;
  assign if_one48.opmode   = s_op;
  assign if_four12.opmode  = s_op;
  assign if_two24.cep  = 1'b1;
  assign if_one48.cep  = 1'b1;
  assign if_four12.cep = 1'b1;

  dsp48e2_simd_alu #(.USE_SIMD("TWO24"), .PREG(0)) u_two24 (
    .clock(clock), .reset(reset), .bus(if_two24));
  dsp48e2_simd_alu #(.USE_SIMD("ONE48"), .PREG(0)) u_one48 (
    .clock(clock), .reset(reset), .bus(if_one48));
  dsp48e2_simd_alu #(.USE_SIMD("FOUR12"), .PREG(0)) u_four12 (
    .clock(clock), .reset(reset), .bus(if_four12));
  dsp48e2_simd_alu #(.USE_SIMD("ONE48"), .PREG(1)) u_acc (
    .clock(clock), .reset(reset), .bus(if_acc));

  task automatic push_exp(input string tag, input logic [47:0] p, input logic [3:0] co);
    exp_t e;
    e.tag = tag;
    e.p   = p;
    e.co  = co;
    sb.push_back(e);
  endtask

  task automatic check_out(input logic [47:0] p_obs, input logic [3:0] co_obs);
    exp_t e;
    checks++;
    assert (sb.size() != 0) else begin
      errors++;
      $error("FAIL sb_empty observed output %h/%b with no expected entry", p_obs, co_obs);
    end
    if (sb.size() != 0) begin
      e = sb.pop_front();
      $display("txn %s p=%h carryout=%b", e.tag, p_obs, co_obs);
      assert (p_obs === e.p) else begin
        errors++;
        $error("FAIL %s_p observed %h expected %h", e.tag, p_obs, e.p);
      end
      checks++;
      assert (co_obs === e.co) else begin
        errors++;
        $error("FAIL %s_co observed %b expected %b", e.tag, co_obs, e.co);
      end
    end
  endtask

  initial begin
    s_ab = '0; s_c = '0; s_cin = 1'b0; s_alu = 4'b0000; s_op = 9'b0;
    if_acc.cep = 1'b0; if_acc.a = '0; if_acc.b = '0; if_acc.c = '0;
    if_acc.carryin = 1'b0; if_acc.alumode = 4'b0000; if_acc.opmode = 9'b000100011;

    repeat (2) @(posedge clock);
    #1;
    push_exp("acc_reset", 48'h0, 4'b0000);
    check_out(if_acc.p, if_acc.carryout);
    reset = 1'b0;

    // Combinational group: add C + AB
    s_op = 9'b000110011; s_alu = 4'b0000;
    s_c = 48'h000005_000003; s_ab = 48'h000007_000004; #1;
    push_exp("t24_add", 48'h00000C_000007, 4'b0000);
    check_out(if_two24.p, if_two24.carryout);

    s_c = 48'h000001_FFFFFF; s_ab = 48'h000002_000001; #1;
    push_exp("t24_wrap", 48'h000003_000000, 4'b0010);
    check_out(if_two24.p, if_two24.carryout);
    push_exp("o48_nowrap", 48'h000004_000000, 4'b0000);
    check_out(if_one48.p, if_one48.carryout);
    push_exp("f12_wrap", 48'h000_003_FFF_000, 4'b0001);
    check_out(if_four12.p, if_four12.carryout);

    s_c = 48'h001_002_FFF_004; s_ab = 48'h001_001_001_001; #1;
    push_exp("f12_add", 48'h002_003_000_005, 4'b0010);
    check_out(if_four12.p, if_four12.carryout);

    s_c = 48'h000010_000003; s_ab = 48'h000001_000005;
    s_alu = 4'b0011; #1;
    push_exp("t24_sub", 48'h00000F_FFFFFE, 4'b0010);
    check_out(if_two24.p, if_two24.carryout);
    s_alu = 4'b0001; #1;
    push_exp("t24_notz", 48'hFFFFF0_000001, 4'b0010);
    check_out(if_two24.p, if_two24.carryout);
    s_alu = 4'b0010; #1;
    push_exp("t24_notsum", 48'hFFFFEE_FFFFF7, 4'b0000);
    check_out(if_two24.p, if_two24.carryout);
    s_alu = 4'b0100; #1;
    push_exp("t24_alu_other", 48'h000011_000008, 4'b0000);
    check_out(if_two24.p, if_two24.carryout);

    // Y all-ones plus carryin: carry stays in lane 0
    s_alu = 4'b0000; s_op = 9'b000001100; s_cin = 1'b1; #1;
    push_exp("t24_yones_cin", 48'hFFFFFF_000000, 4'b0010);
    check_out(if_two24.p, if_two24.carryout);
    push_exp("o48_yones_cin", 48'h000000_000000, 4'b1000);
    check_out(if_one48.p, if_one48.carryout);
    s_cin = 1'b0;

    s_op = 9'b110000000; s_c = 48'h000123_000456; #1;
    push_exp("t24_w_c", 48'h000123_000456, 4'b0000);
    check_out(if_two24.p, if_two24.carryout);

    // P selects on a PREG=0 instance read as zero even with a loaded register
    @(posedge clock); #1;
    s_op = 9'b000100010; #1;
    push_exp("t24_p_sel_zero", 48'h0, 4'b0000);
    check_out(if_two24.p, if_two24.carryout);

    // Registered accumulator: P + AB
    {if_acc.a, if_acc.b} = 48'h1; if_acc.cep = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      push_exp($sformatf("acc_%0d", i), 48'(i), 4'b0000);
      @(posedge clock); #1;
      check_out(if_acc.p, if_acc.carryout);
    end
    if_acc.cep = 1'b0;
    push_exp("acc_hold", 48'h3, 4'b0000);
    @(posedge clock); #1;
    check_out(if_acc.p, if_acc.carryout);
    reset = 1'b1;
    push_exp("acc_rst", 48'h0, 4'b0000);
    @(posedge clock); #1;
    check_out(if_acc.p, if_acc.carryout);
    reset = 1'b0; if_acc.cep = 1'b1;
    push_exp("acc_restart", 48'h1, 4'b0000);
    @(posedge clock); #1;
    check_out(if_acc.p, if_acc.carryout);
    reset = 1'b1;
    push_exp("acc_rst_cep", 48'h0, 4'b0000);
    @(posedge clock); #1;
    check_out(if_acc.p, if_acc.carryout);
    reset = 1'b0;

    if_acc.opmode = 9'b000110011; {if_acc.a, if_acc.b} = 48'h0;
    if_acc.c = 48'h0; if_acc.carryin = 1'b1;
    push_exp("acc_cin", 48'h000000_000001, 4'b0000);
    @(posedge clock); #1;
    check_out(if_acc.p, if_acc.carryout);
    if_acc.carryin = 1'b0;
    {if_acc.a, if_acc.b} = 48'hFFFF_FFFF_FFFF; if_acc.c = 48'h1;
    push_exp("acc_ovf", 48'h0, 4'b1000);
    @(posedge clock); #1;
    check_out(if_acc.p, if_acc.carryout);

    checks++;
    assert (sb.size() == 0) else begin
      errors++;
      $error("FAIL sb_leftover observed %0d entries expected 0", sb.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
